// File: rtl/f1_pkg.sv
// Shared definitions for the f1 exhaustive vector sequencer.
//   state_t   : sequencer FSM states (IDLE, RUN, DONE)
//   VEC_COUNT : number of input vectors in a sweep (all 4-bit patterns)
//   VEC_W     : width of the vector index
//   ERR_W     : width of the mismatch counter (must hold 0..16)
//   LAST_VEC  : index of the final vector of a sweep
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int VEC_COUNT = 16;
  localparam int VEC_W     = 4;
  localparam int ERR_W     = 5;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(VEC_COUNT - 1);

endpackage

// File: rtl/f1_hold_timer.sv
// Hold-time counter for the vector sequencer. Counts enabled cycles from 0 to
// HOLD_CYCLES-1 and wraps back to 0; expire marks the last cycle of a hold.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0 (wins over enable)
//   enable     : count this cycle
//   expire     : combinational, high when enabled and at HOLD_CYCLES-1
module f1_hold_timer #(
  parameter int HOLD_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign expire = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      // Wrapping on expire starts the next vector's hold at 0 without an
      // extra clear from the sequencer.
      cnt <= expire ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/f1_vector_sequencer.sv
// Exhaustive tester for a 4-input boolean function f1. A sweep drives every
// vector {a,b,c,d} = 0..15 for HOLD_CYCLES cycles each, samples f1 on the last
// cycle of each hold and compares it with EXPECTED[vector]. Mismatch count,
// first failing vector and a pass flag are kept until the next sweep.
//
// Handshake: start is a level request sampled only in IDLE; the edge that sees
// start=1 in IDLE accepts it (there is no ready output -- busy/done report
// progress). start in RUN or DONE is ignored.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request a sweep
//   f1          : response of the function under test
//   a, b, c, d  : stimulus bits (a = MSB of vec_idx), 0 outside RUN
//   busy        : sweep in progress (RUN)
//   done        : one-cycle pulse in the DONE state
//   vec_idx     : vector currently driven (holds 15 after a sweep)
//   err_cnt     : mismatches in the current or last sweep
//   fail_valid  : at least one mismatch recorded
//   first_fail  : index of the first mismatching vector
//   pass        : last completed sweep had no mismatches
module f1_vector_sequencer
  import f1_pkg::*;
#(
  parameter int          HOLD_CYCLES = 5,
  parameter logic [15:0] EXPECTED    = 16'h6996
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f1,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] vec_idx,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [VEC_W-1:0] first_fail,
  output logic             pass
);

  state_t           state;
  state_t           state_next;
  logic             expire;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Counter sits at 0 throughout IDLE, so an accepted start always begins
  // vector 0 with a full hold.
  f1_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE),
    .enable(state == RUN),
    .expire(expire)
  );

  assign mismatch = expire && (f1 != EXPECTED[vec_idx]);
  assign err_next = err_cnt + ERR_W'(mismatch);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    {a, b, c, d} = 4'b0000;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy         = 1'b1;
        {a, b, c, d} = vec_idx;
        if (expire && (vec_idx == LAST_VEC)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sweep bookkeeping: vector index, error tracking and the pass verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx    <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if ((state == IDLE) && start) begin
      vec_idx    <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (expire) begin
      err_cnt <= err_next;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        first_fail <= vec_idx;
      end
      if (vec_idx != LAST_VEC) begin
        vec_idx <= vec_idx + 1'b1;
      end else begin
        // Uses err_next so a mismatch on the final sample is reflected in
        // pass during the DONE cycle.
        pass <= (err_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_f1_vector_sequencer.sv
module tb_f1_vector_sequencer;
  import f1_pkg::*;

  localparam int H  = 5;
  localparam int H2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (default parameters) ----------------
  logic       start = 1'b0;
  logic       f1;
  logic       a, b, c, d, busy, done, fail_valid, pass;
  logic [3:0] vec_idx, first_fail;
  logic [4:0] err_cnt;
  int         mode = 0;  // 0: parity, 1: parity inverted on vector 3, 2: tied 0

  function automatic logic f1_fn(input int m, input logic [3:0] v);
    case (m)
      0:       return ^v;
      1:       return (^v) ^ (v == 4'd3);
      default: return 1'b0;
    endcase
  endfunction

  assign f1 = f1_fn(mode, {a, b, c, d});

  f1_vector_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f1(f1),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .vec_idx(vec_idx), .err_cnt(err_cnt), .fail_valid(fail_valid),
    .first_fail(first_fail), .pass(pass)
  );

  // ---------------- DUT (HOLD_CYCLES = 2) ----------------
  logic       start2 = 1'b0;
  logic       f1_2;
  logic       a2, b2, c2, d2, busy2, done2, fail_valid2, pass2;
  logic [3:0] vec_idx2, first_fail2;
  logic [4:0] err_cnt2;

  assign f1_2 = a2 ^ b2 ^ c2 ^ d2;

  f1_vector_sequencer #(.HOLD_CYCLES(H2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .f1(f1_2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
    .vec_idx(vec_idx2), .err_cnt(err_cnt2), .fail_valid(fail_valid2),
    .first_fail(first_fail2), .pass(pass2)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];  // expected final err_cnt of each completed sweep

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (timeline based) ----------------
  // A sweep is described only by the number of edges elapsed since the start
  // was accepted: vector k/H is driven, vectors whose full hold has elapsed
  // have been judged, and edge 16*H lands in the one-cycle DONE phase.
  logic [15:0] exp_bits = 16'h6996;
  bit in_sweep = 0;
  bit have_hist = 0;
  int n_since = 0;
  bit snap[16];
  bit m_pass = 0;

  function automatic int judged_errs(input int k);
    int e = 0;
    for (int v = 0; v < 16; v++) if (((v + 1) * H <= k) && snap[v]) e++;
    return e;
  endfunction

  function automatic int judged_first(input int k);
    for (int v = 0; v < 16; v++) if (((v + 1) * H <= k) && snap[v]) return v;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_sweep  = 0;
      have_hist = 0;
      n_since   = 0;
      m_pass    = 0;
    end else if (in_sweep) begin
      if (n_since == 16 * H) begin
        in_sweep = 0;
      end else begin
        n_since++;
        if (n_since == 16 * H) m_pass = (judged_errs(n_since) == 0);
      end
    end else if (start) begin
      in_sweep  = 1;
      have_hist = 1;
      n_since   = 0;
      m_pass    = 0;
      for (int v = 0; v < 16; v++) snap[v] = (f1_fn(mode, 4'(v)) != exp_bits[v]);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int e_vec, e_err, e_ff, e_run, e_done;
    logic [4:0] q_err;
    if (!have_hist) begin
      e_vec = 0; e_err = 0; e_ff = 0; e_run = 0; e_done = 0;
    end else begin
      e_vec  = (n_since / H > 15) ? 15 : n_since / H;
      e_err  = judged_errs(n_since);
      e_ff   = judged_first(n_since);
      e_run  = (in_sweep && n_since < 16 * H) ? 1 : 0;
      e_done = (in_sweep && n_since == 16 * H) ? 1 : 0;
    end
    check("busy", int'(busy), e_run);
    check("done", int'(done), e_done);
    check("abcd", int'({a, b, c, d}), e_run ? e_vec : 0);
    check("vec_idx", int'(vec_idx), e_vec);
    check("err_cnt", int'(err_cnt), e_err);
    check("fail_valid", int'(fail_valid), (e_err > 0) ? 1 : 0);
    check("first_fail", int'(first_fail), e_ff);
    check("pass", int'(pass), int'(m_pass));
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        q_err = exp_q.pop_front();
        check("sweep_err_cnt", int'(err_cnt), int'(q_err));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Pulses start for one cycle and returns at the negedge where done is seen;
  // cyc is the cycle number counted from the accepting edge (cycle 1 follows
  // that edge), or -1 on timeout.
  task automatic run_sweep(output int cyc);
    @(negedge clk);
    start = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_vec(input int v);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy && vec_idx == 4'(v)) return;
    end
    check("wait_vec_timeout", 0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int pulses;

    // Reset state
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_abcd", int'({a, b, c, d}), 0);
    check("rst_err", int'(err_cnt), 0);
    check("rst_pass", int'(pass), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean parity response
    mode = 0;
    exp_q.push_back(5'd0);
    run_sweep(cyc);
    check("t1_done_cycle", cyc, 81);
    check("t1_err", int'(err_cnt), 0);
    check("t1_pass", int'(pass), 1);
    check("t1_fail_valid", int'(fail_valid), 0);
    repeat (3) @(negedge clk);

    // Vector 3 inverted
    mode = 1;
    exp_q.push_back(5'd1);
    run_sweep(cyc);
    check("t2_err", int'(err_cnt), 1);
    check("t2_first_fail", int'(first_fail), 3);
    check("t2_fail_valid", int'(fail_valid), 1);
    check("t2_pass", int'(pass), 0);
    repeat (3) @(negedge clk);

    // f1 tied low: every odd-parity vector mismatches
    mode = 2;
    exp_q.push_back(5'd8);
    run_sweep(cyc);
    check("t3_err", int'(err_cnt), 8);
    check("t3_first_fail", int'(first_fail), 1);
    check("t3_pass", int'(pass), 0);
    repeat (4) @(negedge clk);
    check("t3_hold_err", int'(err_cnt), 8);

    // start during RUN and on the DONE cycle is ignored
    mode = 0;
    exp_q.push_back(5'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(5);
    start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) start = 1'b1;
      end
    end
    check("t4_done_pulses", pulses, 1);
    check("t4_idle_busy", int'(busy), 0);

    // Asynchronous reset mid-sweep
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(7);
    check("t5_err_before_rst", int'(err_cnt), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_abcd", int'({a, b, c, d}), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_vec", int'(vec_idx), 0);
    check("t5_rst_err", int'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    repeat (5) @(negedge clk);
    check("t5_no_resume", int'(busy), 0);
    exp_q.push_back(5'd0);
    run_sweep(cyc);
    check("t5_done_cycle", cyc, 81);
    check("t5_pass", int'(pass), 1);
    repeat (3) @(negedge clk);

    // HOLD_CYCLES = 2 instance
    @(negedge clk);
    start2 = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2) begin
        cyc = i;
        break;
      end
    end
    check("t6_done_cycle", cyc, 33);
    check("t6_pass", int'(pass2), 1);
    check("t6_err", int'(err_cnt2), 0);

    repeat (2) @(negedge clk);
    check("pending_sweeps", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
